// File: rtl/uart_pkg.sv
// Shared definitions for the UART block family.
// Sequencer state encoding plus the clock/baud defaults used by the UART blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int CLK_FREQ    = 50_000_000;
  localparam int BAUD_RATE   = 115_200;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO for the transmit feeder.
// Flags are registered and are derived from the fill count, not from pointer compare.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  level,
  output logic              overflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic              w_do_push;
  logic              w_do_pop;
  logic [CNT_W-1:0]  w_level_nxt;

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign w_do_push   = push && !r_full;
  assign w_do_pop    = pop && !r_empty;
  assign w_level_nxt = r_level + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == CNT_W'(DEPTH));
      r_empty    <= (w_level_nxt == '0);
      r_overflow <= push && r_full;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head     = r_mem[r_rd_ptr];
  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer driving the UART transmitter's dintx/send.
//   state  | meaning
//   S_IDLE | waiting for a queued byte with tx_done low
//   S_SEND | byte presented, tx_send held until tx_done rises
//   S_GAP  | tx_send low, waiting for tx_done to fall
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = UART_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy
);

  feeder_state_t     r_state;
  logic              r_done_q;
  logic              r_tx_send;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_pop;
  logic              w_done_rise;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (full),
    .empty     (w_empty),
    .level     (level),
    .overflow  (overflow)
  );

  // A stale tx_done left over from the previous byte blocks the next pop.
  assign w_pop       = (r_state == S_IDLE) && !w_empty && !tx_done;
  assign w_done_rise = tx_done && !r_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_done_q  <= 1'b0;
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_done_q <= tx_done;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_send <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_done_rise) begin
            r_tx_send <= 1'b0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (!tx_done) r_state <= S_IDLE;
        end
        default: begin
          r_tx_send <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign empty   = w_empty;
  assign tx_send = r_tx_send;
  assign tx_data = r_tx_data;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus randomized traffic
// against a queue-based model of the FIFO and a behavioural transmitter.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             tx_done = 1'b0;
  logic             full, empty, overflow, tx_send, busy;
  logic [CNT_W-1:0] level;
  logic [7:0]       tx_data;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] m_q[$];
  logic [7:0] m_seen[$];
  int         m_lvl = 0;
  int         m_sends = 0;
  logic       m_rise, m_exp_rise, m_exp_ovf, m_exp_drop, m_send_pre;
  logic       m_done_last = 1'b0;
  logic [7:0] m_head, m_cur;

  // transmitter model
  logic auto_tx = 1'b0;
  int   tx_phase = 0;
  int   tx_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; tx_done = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_q.delete(); m_seen.delete();
    m_lvl = 0; m_done_last = 1'b0; tx_phase = 0; m_sends = 0;
  endtask

  // One clock: drive inputs, advance, then update the model from the rules.
  task automatic step(input logic wr, input logic [7:0] d);
    logic busy_pre, done_pre, acc;
    int   lvl_pre;
    wr_en = wr; wr_data = d;
    if (auto_tx) begin
      case (tx_phase)
        0: if (tx_send) begin tx_cnt = $urandom_range(1, 5); tx_phase = 1; end
           else if ($urandom_range(0, 19) == 0) begin tx_done = 1'b1; tx_phase = 3; end
        1: begin tx_cnt--; if (tx_cnt == 0) begin tx_done = 1'b1; tx_cnt = $urandom_range(1, 3); tx_phase = 2; end end
        2: begin tx_cnt--; if (tx_cnt == 0) begin tx_done = 1'b0; tx_phase = 0; end end
        default: begin tx_done = 1'b0; tx_phase = 0; end
      endcase
    end
    busy_pre = busy; done_pre = tx_done; m_send_pre = tx_send; lvl_pre = m_lvl;
    @(posedge clk); @(negedge clk);
    acc        = wr && (lvl_pre < DEPTH);
    m_exp_ovf  = wr && !acc;
    m_exp_rise = !busy_pre && (lvl_pre > 0) && !done_pre;
    m_exp_drop = m_send_pre && done_pre && !m_done_last;
    m_rise     = tx_send && !m_send_pre;
    m_head     = 8'hxx;
    if (m_rise) begin
      m_sends++;
      m_seen.push_back(tx_data);
      if (m_q.size() > 0) m_head = m_q.pop_front();
      m_cur = m_head;
    end
    if (acc) m_q.push_back(d);
    m_lvl = m_q.size();
    m_done_last = done_pre;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) step(1'b0, 8'h00);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_send got %0b exp 0", tx_send); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
    checks++; if (busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags busy %0b full %0b ovf %0b exp 0 0 0", busy, full, overflow); end
  endtask

  task automatic test_single();
    int held_bad = 0;
    do_reset(); auto_tx = 1'b0;
    step(1'b1, 8'hA5);
    checks++; if (empty !== 1'b0 || level !== CNT_W'(1) || tx_send !== 1'b0) begin errors++; $display("FAIL single_push empty %0b level %0d send %0b exp 0 1 0", empty, level, tx_send); end
    step(1'b0, 8'h00);
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_pop send %0b data %h exp 1 a5", tx_send, tx_data); end
    checks++; if (level !== '0 || empty !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_level level %0d empty %0b busy %0b exp 0 1 1", level, empty, busy); end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'h00);
      if (tx_send !== 1'b1 || tx_data !== 8'hA5) held_bad++;
    end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL single_hold bad_cycles %0d exp 0", held_bad); end
    tx_done = 1'b1;
    step(1'b0, 8'h00);
    checks++; if (tx_send !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_drop send %0b busy %0b exp 0 1", tx_send, busy); end
    step(1'b0, 8'h00); step(1'b0, 8'h00);
    tx_done = 1'b0;
    step(1'b0, 8'h00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_gap_exit busy %0b exp 0", busy); end
    repeat (5) step(1'b0, 8'h00);
    checks++; if (m_sends != 1) begin errors++; $display("FAIL single_count sends %0d exp 1", m_sends); end
  endtask

  task automatic test_back_to_back();
    logic fin = 1'b0;
    do_reset(); auto_tx = 1'b1;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (k < 5) step(1'b1, 8'(k + 1)); else step(1'b0, 8'h00);
      checks++; if (m_rise !== m_exp_rise) begin errors++; $display("FAIL b2b_rise k=%0d got %0b exp %0b", k, m_rise, m_exp_rise); end
      if (m_send_pre) begin
        checks++; if (tx_send !== !m_exp_drop) begin errors++; $display("FAIL b2b_send k=%0d got %0b exp %0b", k, tx_send, !m_exp_drop); end
      end
      if (k >= 5 && m_sends == 5 && !busy && tx_done === 1'b0) fin = 1'b1;
    end
    checks++; if (!fin) begin errors++; $display("FAIL b2b_timeout sends %0d exp 5", m_sends); end
    checks++; if (m_seen.size() != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", m_seen.size()); end
    for (int i = 0; i < m_seen.size() && i < 5; i++) begin
      checks++; if (m_seen[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_order idx %0d got %h exp %h", i, m_seen[i], 8'(i + 1)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b exp 1", empty); end
    auto_tx = 1'b0; tx_done = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset(); auto_tx = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step(1'b1, 8'(k));
      checks++; if (level !== CNT_W'(m_lvl) || overflow !== m_exp_ovf) begin errors++; $display("FAIL ovf_model k=%0d level %0d ovf %0b exp %0d %0b", k, level, overflow, m_lvl, m_exp_ovf); end
      if (k == 2) begin
        checks++; if (tx_send !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL ovf_first send %0b data %h exp 1 01", tx_send, tx_data); end
      end
      if (k == 17) begin
        checks++; if (full !== 1'b1 || level !== CNT_W'(16) || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full full %0b level %0d ovf %0b exp 1 16 0", full, level, overflow); end
      end
      if (k == 18) begin
        checks++; if (overflow !== 1'b1 || level !== CNT_W'(16)) begin errors++; $display("FAIL ovf_drop ovf %0b level %0d exp 1 16", overflow, level); end
      end
    end
    step(1'b0, 8'h00);
    checks++; if (overflow !== 1'b0 || level !== CNT_W'(16)) begin errors++; $display("FAIL ovf_pulse ovf %0b level %0d exp 0 16", overflow, level); end
  endtask

  task automatic test_push_pop_full();
    tx_done = 1'b1; step(1'b0, 8'h00);
    checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL ppf_drop send %0b exp 0", tx_send); end
    tx_done = 1'b0; step(1'b0, 8'h00);
    checks++; if (busy !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ppf_idle busy %0b full %0b exp 0 1", busy, full); end
    step(1'b1, 8'hEE);
    checks++; if (overflow !== 1'b1 || level !== CNT_W'(15) || full !== 1'b0) begin errors++; $display("FAIL ppf_reject ovf %0b level %0d full %0b exp 1 15 0", overflow, level, full); end
    checks++; if (tx_send !== 1'b1 || tx_data !== 8'h02) begin errors++; $display("FAIL ppf_pop send %0b data %h exp 1 02", tx_send, tx_data); end
  endtask

  task automatic test_reset_mid();
    do_reset(); auto_tx = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h10 + k));
    checks++; if (tx_send !== 1'b1 || level !== CNT_W'(3)) begin errors++; $display("FAIL rmid_setup send %0b level %0d exp 1 3", tx_send, level); end
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    m_q.delete(); m_lvl = 0; m_done_last = 1'b0; m_sends = 0;
    checks++; if (tx_send !== 1'b0 || level !== '0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_clear send %0b level %0d empty %0b busy %0b exp 0 0 1 0", tx_send, level, empty, busy); end
    tx_done = 1'b1; step(1'b0, 8'h00); step(1'b0, 8'h00);
    tx_done = 1'b0; repeat (5) step(1'b0, 8'h00);
    checks++; if (m_sends != 0 || tx_send !== 1'b0) begin errors++; $display("FAIL rmid_nosend sends %0d send %0b exp 0 0", m_sends, tx_send); end
  endtask

  task automatic test_random();
    logic fin = 1'b0;
    do_reset(); auto_tx = 1'b1;
    for (int k = 0; k < 2500 && !fin; k++) begin
      if (k < 300)      step($urandom_range(0, 3) != 0, 8'($urandom));
      else if (k < 800) step($urandom_range(0, 7) == 0, 8'($urandom));
      else              step(1'b0, 8'h00);
      checks++; if (m_rise !== m_exp_rise) begin errors++; $display("FAIL rnd_rise k=%0d got %0b exp %0b", k, m_rise, m_exp_rise); end
      if (m_rise) begin
        checks++; if (tx_data !== m_head) begin errors++; $display("FAIL rnd_data k=%0d got %h exp %h", k, tx_data, m_head); end
      end
      if (m_send_pre) begin
        checks++; if (tx_send !== !m_exp_drop) begin errors++; $display("FAIL rnd_send k=%0d got %0b exp %0b", k, tx_send, !m_exp_drop); end
        if (tx_send) begin
          checks++; if (tx_data !== m_cur) begin errors++; $display("FAIL rnd_stable k=%0d got %h exp %h", k, tx_data, m_cur); end
        end
      end
      checks++; if (level !== CNT_W'(m_lvl)) begin errors++; $display("FAIL rnd_level k=%0d got %0d exp %0d", k, level, m_lvl); end
      checks++; if (full !== (m_lvl == DEPTH) || empty !== (m_lvl == 0)) begin errors++; $display("FAIL rnd_flags k=%0d full %0b empty %0b exp lvl %0d", k, full, empty, m_lvl); end
      checks++; if (overflow !== m_exp_ovf) begin errors++; $display("FAIL rnd_ovf k=%0d got %0b exp %0b", k, overflow, m_exp_ovf); end
      if (k >= 800 && m_lvl == 0 && !busy && tx_phase == 0) fin = 1'b1;
    end
    checks++; if (!fin) begin errors++; $display("FAIL rnd_timeout level %0d busy %0b exp drained", level, busy); end
    auto_tx = 1'b0; tx_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
